chimera_clu_gate_ctrl: RTL and testbench

Per-cluster clock-gating sequencer for the cluster domain. It sits between the top-level register file's per-cluster clock-gate bits and the `tc_clk_gating` cells. Before a cluster's clock is stopped, the block isolates that cluster's narrow AXI slave port and drains its outstanding transactions. On wake-up, it re-enables the clock and holds isolation for a fixed settle window.

---
 rtl/chimera_clu_gate_ctrl.sv | 123 ++++++++++++
 tb/tb_chimera_clu_gate_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/chimera_clu_gate_ctrl.sv
// rtl/chimera_clu_gate_ctrl.sv - per-cluster clock-gate sequencer: isolate, drain, gate, wake.
// Optional drain timeout enabled by defining CHIMERA_CLU_GATE_TIMEOUT_EN.
module chimera_clu_gate_ctrl #(
    parameter int unsigned NumClusters   = 5,
    parameter int unsigned OutstWidth    = 4,
    parameter int unsigned WakeCycles    = 4,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumClusters-1:0]   gate_req_i,
    input  logic [2*NumClusters-1:0] txn_start_i,
    input  logic [2*NumClusters-1:0] txn_done_i,
    output logic [NumClusters-1:0]   isolate_o,
    output logic [NumClusters-1:0]   clk_en_o,
    output logic [NumClusters-1:0]   gated_o,
    output logic [NumClusters-1:0]   timeout_o
);

    typedef enum logic [1:0] {RUN, DRAIN, GATED, WAKE} clu_state_e;

    localparam int unsigned WakeW = (WakeCycles > 1) ? $clog2(WakeCycles) : 1;
    localparam logic [OutstWidth-1:0] CntMax  = '1;
    localparam logic [OutstWidth-1:0] CntHigh = {{(OutstWidth-1){1'b1}}, 1'b0};

    for (genvar c = 0; c < NumClusters; c++) begin : g_clu
        clu_state_e            state_q, state_d;
        logic [OutstWidth-1:0] cnt_q, cnt_d;
        logic [WakeW-1:0]      wake_q, wake_d;
        logic [1:0]            st, dn, pop_s, pop_d;
        logic [OutstWidth:0]   sum_up, diff;
        logic                  busy, to_hit, to_block;

        assign st    = txn_start_i[2*c +: 2];
        assign dn    = txn_done_i[2*c +: 2];
        assign pop_s = {1'b0, st[1]} + {1'b0, st[0]};
        assign pop_d = {1'b0, dn[1]} + {1'b0, dn[0]};
        assign busy  = (|st) | (|dn);

        // Saturating outstanding counter, evaluated one bit wider than cnt
        always_comb begin
            sum_up = {1'b0, cnt_q} + {{(OutstWidth-1){1'b0}}, pop_s};
            diff   = '0;
            cnt_d  = '0;
            if (sum_up >= {{(OutstWidth-1){1'b0}}, pop_d}) begin
                diff  = sum_up - {{(OutstWidth-1){1'b0}}, pop_d};
                cnt_d = diff[OutstWidth] ? CntMax : diff[OutstWidth-1:0];
            end
        end

        always_comb begin
            state_d = state_q;
            wake_d  = wake_q;
            unique case (state_q)
                RUN: begin
                    if (gate_req_i[c] && !to_block) state_d = DRAIN;
                end
                DRAIN: begin
                    if (!gate_req_i[c])               state_d = RUN;
                    else if (cnt_q == '0 && !busy)    state_d = GATED;
                    else if (to_hit)                  state_d = RUN;
                end
                GATED: begin
                    if (!gate_req_i[c]) begin
                        state_d = WAKE;
                        wake_d  = WakeW'(WakeCycles - 1);
                    end
                end
                WAKE: begin
                    if (wake_q == '0) state_d = RUN;
                    else              wake_d  = wake_q - WakeW'(1);
                end
                default: state_d = RUN;
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= RUN;
                cnt_q   <= '0;
                wake_q  <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                wake_q  <= wake_d;
            end
        end

`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
        localparam int unsigned TimerW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
        logic [TimerW-1:0] timer_q;
        logic              to_q;

        assign to_hit   = (timer_q == TimerW'(TimeoutCycles - 1));
        assign to_block = to_q;

        // Timer only advances while staying in DRAIN; the flag holds until the request drops
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                timer_q <= '0;
                to_q    <= 1'b0;
            end else begin
                timer_q <= (state_q == DRAIN && state_d == DRAIN) ? timer_q + TimerW'(1) : '0;
                if (!gate_req_i[c])
                    to_q <= 1'b0;
                else if (state_q == DRAIN && state_d == RUN)
                    to_q <= 1'b1;
            end
        end

        assign timeout_o[c] = to_q;
`else
        assign to_hit       = 1'b0;
        assign to_block     = 1'b0;
        assign timeout_o[c] = 1'b0;
`endif

        assign clk_en_o[c]  = (state_q != GATED);
        assign gated_o[c]   = (state_q == GATED);
        assign isolate_o[c] = (state_q != RUN) || (cnt_q >= CntHigh);
    end

endmodule

// File: tb/tb_chimera_clu_gate_ctrl.sv
// tb/tb_chimera_clu_gate_ctrl.sv - scoreboard bench for chimera_clu_gate_ctrl.
module tb_chimera_clu_gate_ctrl;
    localparam int NC = 5;
    localparam int OW = 4;
    localparam int WC = 4;
    localparam int TC = 16;
    localparam int CMAX = (1 << OW) - 1;
`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NC-1:0]   gate_req = '0;
    logic [2*NC-1:0] txn_start = '0;
    logic [2*NC-1:0] txn_done = '0;
    logic [NC-1:0]   isolate, clk_en, gated, timeout;

    always #5 clk = ~clk;

    chimera_clu_gate_ctrl #(
        .NumClusters(NC), .OutstWidth(OW), .WakeCycles(WC), .TimeoutCycles(TC)
    ) dut (
        .clk_i(clk), .rst_i(rst), .gate_req_i(gate_req),
        .txn_start_i(txn_start), .txn_done_i(txn_done),
        .isolate_o(isolate), .clk_en_o(clk_en), .gated_o(gated), .timeout_o(timeout)
    );

    typedef struct packed {
        logic [NC-1:0] iso;
        logic [NC-1:0] ce;
        logic [NC-1:0] gt;
        logic [NC-1:0] to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference: mode 0=running 1=draining 2=gated 3=waking
    int m_mode[NC];
    int m_cnt[NC];
    int m_wake_left[NC];
    int m_drain_age[NC];
    bit m_to[NC];

    function automatic exp_t model_out();
        exp_t e;
        for (int c = 0; c < NC; c++) begin
            e.ce[c]  = (m_mode[c] != 2);
            e.gt[c]  = (m_mode[c] == 2);
            e.iso[c] = (m_mode[c] != 0) || (m_cnt[c] >= CMAX - 1);
            e.to[c]  = m_to[c];
        end
        return e;
    endfunction

    function automatic void model_step(input logic r, input logic [NC-1:0] req,
                                       input logic [2*NC-1:0] s, input logic [2*NC-1:0] d);
        for (int c = 0; c < NC; c++) begin
            int ps, pd, n;
            if (r) begin
                m_mode[c] = 0; m_cnt[c] = 0; m_wake_left[c] = 0;
                m_drain_age[c] = 0; m_to[c] = 0;
                continue;
            end
            ps = int'(s[2*c]) + int'(s[2*c+1]);
            pd = int'(d[2*c]) + int'(d[2*c+1]);
            case (m_mode[c])
                0: if (req[c] && !m_to[c]) begin m_mode[c] = 1; m_drain_age[c] = 0; end
                1: begin
                    if (!req[c]) m_mode[c] = 0;
                    else if (m_cnt[c] == 0 && ps == 0 && pd == 0) m_mode[c] = 2;
                    else if (TO_EN && m_drain_age[c] == TC - 1) begin
                        m_mode[c] = 0; m_to[c] = 1;
                    end else m_drain_age[c]++;
                end
                2: if (!req[c]) begin m_mode[c] = 3; m_wake_left[c] = WC; end
                default: begin
                    m_wake_left[c]--;
                    if (m_wake_left[c] == 0) m_mode[c] = 0;
                end
            endcase
            if (!req[c]) m_to[c] = 0;
            n = m_cnt[c] + ps - pd;
            m_cnt[c] = (n < 0) ? 0 : (n > CMAX) ? CMAX : n;
        end
    endfunction

    task automatic step(input logic r, input logic [NC-1:0] req,
                        input logic [2*NC-1:0] s, input logic [2*NC-1:0] d);
        @(negedge clk);
        rst = r; gate_req = req; txn_start = s; txn_done = d;
        model_step(r, req, s, d);
        exp_q.push_back(model_out());
    endtask

    task automatic chk(input string name, input logic [NC-1:0] act, input logic [NC-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cycle, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("isolate", isolate, e.iso);
                chk("clk_en", clk_en, e.ce);
                chk("gated", gated, e.gt);
                chk("timeout", timeout, e.to);
            end
        end
    end

    initial begin : stimulus
        logic [NC-1:0]   req;
        logic [2*NC-1:0] s, d;
        req = '0;
        repeat (2) step(1'b1, '0, '0, '0);
        repeat (2) step(1'b0, '0, '0, '0);
        // Idle gating of cluster 2
        req = 5'b00100;
        repeat (4) step(1'b0, req, '0, '0);
        // Cluster 0: three AR starts, then drain one done at a time
        repeat (3) step(1'b0, req, 10'b10, '0);
        req[0] = 1'b1;
        repeat (3) step(1'b0, req, '0, '0);
        repeat (3) begin
            step(1'b0, req, '0, 10'b10);
            step(1'b0, req, '0, '0);
        end
        step(1'b0, req, '0, '0);
        // Wake cluster 0, re-request mid-wake
        req[0] = 1'b0;
        repeat (2) step(1'b0, req, '0, '0);
        req[0] = 1'b1;
        repeat (6) step(1'b0, req, '0, '0);
        // Cluster 1 backpressure and underflow
        repeat (7) step(1'b0, req, 10'b1100, '0);
        step(1'b0, req, '0, '0);
        step(1'b0, req, '0, 10'b0100);
        repeat (14) step(1'b0, req, '0, 10'b0100);
        step(1'b0, req, '0, '0);
        // Cluster 4 drain stuck at cnt=1
        step(1'b0, req, 10'b01_0000_0000, '0);
        req[4] = 1'b1;
        repeat (20) step(1'b0, req, '0, '0);
        req[4] = 1'b0;
        repeat (2) step(1'b0, req, '0, '0);
        step(1'b0, req, '0, 10'b01_0000_0000);
        // Reset while cluster 3 gated
        req[3] = 1'b1;
        repeat (3) step(1'b0, req, '0, '0);
        step(1'b1, req, '0, '0);
        req = '0;
        repeat (2) step(1'b0, req, '0, '0);
        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(99) < 6) req[c] = ~req[c];
                for (int b = 0; b < 2; b++) begin
                    s[2*c+b] = ($urandom_range(99) < 25);
                    d[2*c+b] = ($urandom_range(99) < ((m_cnt[c] > 0) ? 35 : 4));
                end
            end
            step(($urandom_range(999) < 3), req, s, d);
        end
        step(1'b0, req, '0, '0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
